// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// Fetch front-end additions cover the SQI read sequence.
package idli_pkg;

   typedef logic [1:0]  ctr_t;
   typedef logic [15:0] data_t;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA
   } fe_state_t;

   localparam logic [7:0] SQI_CMD_READ      = 8'h03;
   localparam logic [2:0] SQI_ADDR_NIBBLES  = 3'd6;
   localparam logic [2:0] SQI_DUMMY_NIBBLES = 3'd2;

   // Nibble idx (0 = most significant) of a 24b SQI byte address.
   function automatic logic [3:0] sqi_addr_nibble(input logic [23:0] addr,
                                                  input logic [2:0]  idx);
      logic [23:0] sh;
      sh = addr >> (5'd20 - {idx, 2'b00});
      return sh[3:0];
   endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch: streams 16b words from SQI memory as a sequential
// quad read, one word per 4-cycle GCK period, restarting on redirect.
module idli_fetch_m
   import idli_pkg::*;
(
   input  logic        i_fe_gck,
   input  logic        i_fe_rst,
   input  logic        i_fe_redir,
   input  logic [15:0] i_fe_redir_pc,
   output logic [1:0]  o_fe_ctr,
   output logic [15:0] o_fe_enc,
   output logic        o_fe_enc_vld,
   output logic [15:0] o_fe_pc,
   output logic        o_fe_sqi_cs_n,
   output logic [3:0]  o_fe_sqi_sio,
   output logic        o_fe_sqi_oe,
   input  logic [3:0]  i_fe_sqi_sio
);

   fe_state_t   state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   ctr_t        ctr_reg;
   logic [15:0] pc_reg, pc_next;
   logic [11:0] shift_reg;
   logic        cs_n_reg, cs_n_next;
   logic        oe_reg, oe_next;
   logic [3:0]  sio_reg, sio_next;
   logic        redir;
   logic [23:0] byte_addr;

   assign redir     = i_fe_redir && (ctr_reg == 2'd3);
   assign byte_addr = {7'b0, pc_reg, 1'b0};

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pc_next    = pc_reg;
      case (state_reg)
         IDLE: begin
            // Entering CMD at ctr==2 lands the first DATA cycle on ctr==0.
            if (ctr_reg == 2'd1) begin
               state_next = CMD;
               cnt_next   = 3'd0;
            end
         end
         CMD: begin
            if (cnt_reg == 3'd1) begin
               state_next = ADDR;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         ADDR: begin
            if (cnt_reg == SQI_ADDR_NIBBLES - 3'd1) begin
               state_next = DUMMY;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         DUMMY: begin
            if (cnt_reg == SQI_DUMMY_NIBBLES - 3'd1) begin
               state_next = DATA;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         DATA: begin
            if (ctr_reg == 2'd3) begin
               pc_next = pc_reg + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 3'd0;
         end
      endcase
      if (redir) begin
         state_next = IDLE;
         cnt_next   = 3'd0;
         pc_next    = i_fe_redir_pc;
      end
   end

   // SQI pins are registered, so they are decoded from the next state.
   always_comb begin
      cs_n_next = 1'b1;
      oe_next   = 1'b0;
      sio_next  = 4'h0;
      case (state_next)
         CMD: begin
            cs_n_next = 1'b0;
            oe_next   = 1'b1;
            sio_next  = (cnt_next == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
         end
         ADDR: begin
            cs_n_next = 1'b0;
            oe_next   = 1'b1;
            sio_next  = sqi_addr_nibble(byte_addr, cnt_next);
         end
         DUMMY, DATA: begin
            cs_n_next = 1'b0;
         end
         default: begin
            cs_n_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_fe_gck or posedge i_fe_rst) begin
      if (i_fe_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 3'd0;
         ctr_reg   <= 2'd0;
         pc_reg    <= 16'h0000;
         shift_reg <= 12'h000;
         cs_n_reg  <= 1'b1;
         oe_reg    <= 1'b0;
         sio_reg   <= 4'h0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ctr_reg   <= ctr_reg + 2'd1;
         pc_reg    <= pc_next;
         cs_n_reg  <= cs_n_next;
         oe_reg    <= oe_next;
         sio_reg   <= sio_next;
         if (state_reg == DATA) begin
            shift_reg <= {shift_reg[7:0], i_fe_sqi_sio};
         end
      end
   end

   assign o_fe_ctr      = ctr_reg;
   assign o_fe_enc      = {shift_reg, i_fe_sqi_sio};
   assign o_fe_enc_vld  = (state_reg == DATA) && (ctr_reg == 2'd3) && !i_fe_redir;
   assign o_fe_pc       = pc_reg;
   assign o_fe_sqi_cs_n = cs_n_reg;
   assign o_fe_sqi_oe   = oe_reg;
   assign o_fe_sqi_sio  = sio_reg;

endmodule

// File: doc/idli_fetch_m.md
# idli_fetch_m

Instruction fetch front end. Drives the SQI instruction memory with a sequential quad-read and assembles each 16b instruction from four nibbles. Owns the free-running sync counter that paces the 4-cycle GCK period. Presents the encoding, its valid flag and the counter to the decode stage, which flops the encoding on the edge where the counter is 3. Restarts the memory stream at a new PC on a branch redirect.

## Interface
Parameters:
- none. Constants live in the shared package.

Ports:
- `i_fe_gck` in 1: GCK clock.
- `i_fe_rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `i_fe_redir` in 1: redirect request. Only honoured in a cycle where ctr==3.
- `i_fe_redir_pc` in 16: redirect target, as a word address.
- `o_fe_ctr` out 2 (`ctr_t`): sync counter.
- `o_fe_enc` out 16 (`data_t`): instruction encoding.
- `o_fe_enc_vld` out 1: `o_fe_enc` is valid. Only ever high when ctr==3.
- `o_fe_pc` out 16: word address of `o_fe_enc`.
- `o_fe_sqi_cs_n` out 1: memory chip select, active low.
- `o_fe_sqi_sio` out 4: nibble driven to memory.
- `o_fe_sqi_oe` out 1: output enable for `o_fe_sqi_sio`.
- `i_fe_sqi_sio` in 4: nibble read from memory. Sampled on posedge.

## Operation
Reset values:
- ctr=0, state=IDLE, pc_q=0x0000, shift_q=0.
- cs_n=1, oe=0, sio=0x0, enc_vld=0.

Counter:
- ctr increments every cycle and wraps 3→0.

FSM states and transitions (all SQI outputs registered):
- **IDLE**: cs_n=1, oe=0. Go to CMD on the edge where ctr==1, so CMD's first cycle has ctr==2.
- **CMD** (2 cycles): cs_n=0, oe=1. sio = 0x0, then 0x3 (`SQI_CMD_READ`=8'h03).
- **ADDR** (6 cycles): oe=1. sio carries byte address {7'b0, pc_q, 1'b0}, MSB nibble first.
- **DUMMY** (2 cycles): oe=0, sio=0.
- **DATA** (unbounded): oe=0. The first DATA cycle always has ctr==0.
  - Each cycle: shift_q <= {shift_q[7:0], i_fe_sqi_sio}.
  - Encoding output: o_fe_enc = {shift_q[11:0], i_fe_sqi_sio}, combinational.
  - o_fe_enc_vld = (state==DATA) && ctr==3 && !(i_fe_redir).
  - At a ctr==3 cycle in DATA with no redirect: pc_q <= pc_q+1, wrapping 0xFFFF→0x0000. The memory stream auto-increments and needs no new command.

Redirect (`i_fe_redir` && ctr==3, in any state):
- pc_q <= i_fe_redir_pc.
- Next state is IDLE, so cs_n rises next cycle.
- The word presented in the redirect cycle is suppressed (vld=0).

Other rules:
- Redirect when ctr!=3: ignored entirely.
- A redirect that lands during CMD/ADDR/DUMMY aborts that transaction.
- Redirect while already in IDLE: only pc_q is updated.
- o_fe_pc = pc_q.
- o_fe_enc is a don't-care whenever vld=0.
- Async reset asserted mid-transaction: all outputs go to reset values immediately. The restart is from pc 0.

## Timing
- After reset release (cycle 0 = first cycle with ctr==0):
  - IDLE in cycles 0–1, CMD in 2–3, ADDR in 4–9, DUMMY in 10–11.
  - First word is shifted in over cycles 12–15; vld=1 in cycle 15.
- Steady state: one valid word every 4 cycles, always at ctr==3.
- Redirect in cycle T (ctr==3):
  - cs_n high in cycles T+1 and T+2 (at least 2 cycles, which satisfies the memory's deselect minimum).
  - CMD starts at T+3; first new word is valid in cycle T+16.
- Decode samples enc/vld on the edge ending the ctr==3 cycle. No other handshake exists; fetch never stalls.

## Structure
- Shared package (`idli_pkg`) additions:
  - `fe_state_t` enum: IDLE, CMD, ADDR, DUMMY, DATA.
  - `SQI_CMD_READ`.
  - `SQI_ADDR_NIBBLES`=6 and `SQI_DUMMY_NIBBLES`=2.
  - Reuses the existing `ctr_t` and `data_t`.
- Single module. The per-state nibble count is a 3b counter local to the FSM. No sub-module is warranted.

## Test plan
- **Reset release, memory returns A,B,C,D in cycles 12–15.**
  - cs_n: 1 in cycles 0–1, 0 from cycle 2.
  - sio: 0,3 then 0,0,0,0,0,0; oe=0 in cycles 10–11.
  - Cycle 15: enc=0xABCD, vld=1, pc=0x0000.
- **Continuous streaming.** Words 0x1111, 0x2222 follow → vld in cycles 19 and 23 with pc=1 and 2. vld=0 in all cycles with ctr!=3.
- **Redirect to 0x1234 at cycle 19 (ctr==3).**
  - vld=0 in cycle 19; cs_n=1 in cycles 20–21.
  - Address nibbles 0,0,2,4,6,8 in cycles 24–29; next vld in cycle 35 with pc=0x1234.
- **Redirect asserted at ctr==1 and ctr==2** → ignored; stream and pc unchanged.
- **Redirect at ctr==3 during ADDR (cycle 7) to 0x0040** → cs_n high in cycles 8–9; new CMD in cycle 10 with address nibbles 000080.
- **Wrap and async reset.**
  - Redirect to 0xFFFF → address nibbles 01FFFE; two words presented with pc 0xFFFF then 0x0000.
  - Then assert rst mid-DATA → cs_n=1, vld=0, ctr=0 immediately.
